// File: rtl/apb_rr_arbiter_pkg.sv
// apb_rr_arbiter_pkg: shared FSM state type and round-robin search helper
package apb_rr_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    localparam int MAX_REQ = 16;
    function automatic int rr_next(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
        int win;
        win = 0;
        for (int i = MAX_REQ - 1; i >= 0; i--)
            if (i < n && req[4'((ptr + i) % n)])
                win = (ptr + i) % n;
        return win;
    endfunction
endpackage

// File: rtl/apb_rr_picker.sv
// apb_rr_picker: combinational round-robin pick, first set bit at or above i_ptr with wrap
module apb_rr_picker
    import apb_rr_arbiter_pkg::*;
#(
    parameter int NB_REQ = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NB_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [NB_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_valid
);
    logic [MAX_REQ-1:0] w_req;
    always_comb begin
        w_req = '0;
        w_req[NB_REQ-1:0] = i_req;
        o_valid = |i_req;
        o_idx = IDX_W'(rr_next(w_req, int'(i_ptr), NB_REQ));
        o_grant = o_valid ? NB_REQ'(1) << o_idx : '0;
    end
endmodule

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: round-robin share of one downstream APB master among NB_REQ requesters
module apb_rr_arbiter
    import apb_rr_arbiter_pkg::*;
#(
    parameter int NB_REQ         = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NB_REQ-1:0]                  req_psel_i,
    input  logic [NB_REQ-1:0]                  req_penable_i,
    input  logic [NB_REQ-1:0]                  req_pwrite_i,
    input  logic [NB_REQ*APB_ADDR_WIDTH-1:0]   req_paddr_i,
    input  logic [NB_REQ*APB_DATA_WIDTH-1:0]   req_pwdata_i,
    output logic [NB_REQ*APB_DATA_WIDTH-1:0]   req_prdata_o,
    output logic [NB_REQ-1:0]                  req_pready_o,
    output logic [NB_REQ-1:0]                  req_pslverr_o,
    output logic                               psel_o,
    output logic                               penable_o,
    output logic                               pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]          paddr_o,
    output logic [APB_DATA_WIDTH-1:0]          pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0]          prdata_i,
    input  logic                               pready_i,
    input  logic                               pslverr_i,
    output logic [NB_REQ-1:0]                  grant_o,
    output logic                               busy_o
);
    localparam int IDX_W = $clog2(NB_REQ);
    localparam int AW = APB_ADDR_WIDTH;
    localparam int DW = APB_DATA_WIDTH;

    state_t              r_state, w_next;
    logic [IDX_W-1:0]    r_ptr, r_idx, w_idx;
    logic [NB_REQ-1:0]   r_grant, w_grant;
    logic                r_psel, r_penable, r_pwrite, w_valid, w_done;
    logic [AW-1:0]       r_paddr;
    logic [DW-1:0]       r_pwdata;

    apb_rr_picker #(.NB_REQ(NB_REQ), .IDX_W(IDX_W)) u_picker (
        .i_req   (req_psel_i),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    always_comb begin
        w_next = r_state == IDLE  ? (w_valid ? SETUP : IDLE) :
                 r_state == SETUP ? ACCESS :
                 (pready_i ? IDLE : ACCESS);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr     <= '0;
            r_idx     <= '0;
            r_grant   <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
        end else if (r_state == IDLE) begin
            if (w_valid) begin
                r_grant  <= w_grant;
                r_idx    <= w_idx;
                r_psel   <= 1'b1;
                r_pwrite <= req_pwrite_i[w_idx];
                r_paddr  <= req_paddr_i[w_idx*AW +: AW];
                r_pwdata <= req_pwdata_i[w_idx*DW +: DW];
            end
        end else if (r_state == SETUP) begin
            r_penable <= 1'b1;
        end else if (pready_i) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_grant   <= '0;
            r_ptr     <= r_idx == IDX_W'(NB_REQ - 1) ? '0 : r_idx + 1'b1;
        end
    end

    assign w_done = r_state == ACCESS && pready_i;

    always_comb begin
        req_pready_o  = w_done ? r_grant : '0;
        req_pslverr_o = (w_done && pslverr_i) ? r_grant : '0;
        req_prdata_o  = '0;
        for (int k = 0; k < NB_REQ; k++)
            req_prdata_o[k*DW +: DW] = (w_done && r_grant[k]) ? prdata_i : '0;
    end

    assign psel_o    = r_psel;
    assign penable_o = r_penable;
    assign pwrite_o  = r_pwrite;
    assign paddr_o   = r_paddr;
    assign pwdata_o  = r_pwdata;
    assign grant_o   = r_grant;
    assign busy_o    = r_state != IDLE;

    // the owner must keep its request up until the downstream transfer completes
    a_owner_holds: assert property (@(posedge clk_i) disable iff (rst_i)
        (r_state != IDLE) |-> |(req_psel_i & req_penable_i & r_grant));
endmodule
